// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// sign fix-up cycle, and a stall handshake for HI/LO accesses while an operation runs.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] mf_data
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1A;
   localparam logic [5:0] F_DIVU  = 6'h1B;

   logic [1:0]       state_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] acc_hi_reg, acc_lo_reg, op_reg, a_raw_reg;
   logic             is_div_reg, neg_res_reg, neg_rem_reg, div0_reg;
   logic [WIDTH-1:0] hi_reg, lo_reg;
   logic             done_reg;

   logic             is_hilo, is_op, is_mt, accept_op, accept_mt;
   logic             signed_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   assign is_op   = (funct == F_MULT) || (funct == F_MULTU) || (funct == F_DIV) || (funct == F_DIVU);
   assign is_mt   = (funct == F_MTHI) || (funct == F_MTLO);
   assign is_hilo = is_op || is_mt || (funct == F_MFHI) || (funct == F_MFLO);

   assign busy      = (state_reg != IDLE);
   assign stall     = req_valid && busy && is_hilo;
   assign accept_op = req_valid && !stall && !flush && is_op;
   assign accept_mt = req_valid && !stall && !flush && is_mt;

   assign signed_op = (funct == F_MULT) || (funct == F_DIV);
   assign a_neg     = signed_op && src_a[WIDTH-1];
   assign b_neg     = signed_op && src_b[WIDTH-1];
   assign a_mag     = a_neg ? -src_a : src_a;
   assign b_mag     = b_neg ? -src_b : src_b;

   // One iteration: multiply keeps {acc_hi, acc_lo} as partial product / remaining multiplier,
   // divide keeps acc_hi as partial remainder and shifts quotient bits into acc_lo.
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0] acc_hi_next, acc_lo_next;

   always_comb begin
      mul_sum     = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, op_reg} : '0);
      div_shift   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
      div_diff    = div_shift - {1'b0, op_reg};
      acc_hi_next = mul_sum[WIDTH:1];
      acc_lo_next = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
      if (is_div_reg) begin
         acc_hi_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
         acc_lo_next = {acc_lo_reg[WIDTH-2:0], ~div_diff[WIDTH]};
      end
   end

   logic [2*WIDTH-1:0] prod, prod_neg;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   always_comb begin
      prod     = {acc_hi_reg, acc_lo_reg};
      prod_neg = -prod;
      fix_hi   = neg_res_reg ? prod_neg[2*WIDTH-1:WIDTH] : acc_hi_reg;
      fix_lo   = neg_res_reg ? prod_neg[WIDTH-1:0] : acc_lo_reg;
      if (is_div_reg) begin
         fix_hi = neg_rem_reg ? -acc_hi_reg : acc_hi_reg;
         fix_lo = neg_res_reg ? -acc_lo_reg : acc_lo_reg;
         if (div0_reg) begin
            fix_hi = a_raw_reg;
            fix_lo = '1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         acc_hi_reg  <= '0;
         acc_lo_reg  <= '0;
         op_reg      <= '0;
         a_raw_reg   <= '0;
         is_div_reg  <= 1'b0;
         neg_res_reg <= 1'b0;
         neg_rem_reg <= 1'b0;
         div0_reg    <= 1'b0;
         hi_reg      <= '0;
         lo_reg      <= '0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (flush) begin
            state_reg <= IDLE;
         end else begin
            case (state_reg)
               IDLE: begin
                  if (accept_op) begin
                     state_reg   <= RUN;
                     cnt_reg     <= '0;
                     acc_hi_reg  <= '0;
                     acc_lo_reg  <= a_mag;
                     op_reg      <= b_mag;
                     a_raw_reg   <= src_a;
                     is_div_reg  <= funct[1];
                     neg_res_reg <= a_neg ^ b_neg;
                     neg_rem_reg <= a_neg;
                     div0_reg    <= (src_b == '0);
                  end else if (accept_mt) begin
                     if (funct == F_MTHI) hi_reg <= src_a;
                     else                 lo_reg <= src_a;
                  end
               end
               RUN: begin
                  acc_hi_reg <= acc_hi_next;
                  acc_lo_reg <= acc_lo_next;
                  cnt_reg    <= cnt_reg + CW'(1);
                  if (cnt_reg == LAST) state_reg <= FIX;
               end
               FIX: begin
                  hi_reg    <= fix_hi;
                  lo_reg    <= fix_lo;
                  done_reg  <= 1'b1;
                  state_reg <= IDLE;
               end
               default: state_reg <= IDLE;
            endcase
         end
      end
   end

   assign done    = done_reg;
   assign hi_o    = hi_reg;
   assign lo_o    = lo_reg;
   assign mf_data = (funct == F_MFHI) ? hi_reg : lo_reg;
endmodule
